adder_acc: RTL and testbench
============================

# adder_acc

Streaming accumulator directly downstream of `adder`. It takes the (W+1)-bit sums the adder produces, reduces every LEN consecutive accepted sums into one total, and presents the total saturated to OW bits together with a saturation flag. It is the reduction stage used for dot-product partial sums in the attention datapath.

## Interface

Parameters:
- `W`, 16: operand width of the upstream adder. The input sample is W+1 bits.
- `LEN`, 4: number of samples per result. Must be at least 1.
- `OW`, 16: width of the saturated result.

Derived, not overridable:
- `ACC_W` = W+1+$clog2(LEN). This is the internal accumulator width and cannot overflow.

Ports:
- `I_CLK`  in  1  clock. All logic is on the rising edge.
- `I_RST_N`  in  1  reset, synchronous, active-low. There is one clock domain.
- `I_DATA`  in  W+1  unsigned sample, driven from the adder's `O_OUT`.
- `I_VLD`  in  1  `I_DATA` is valid.
- `O_RDY`  out  1  block will accept a sample. Registered.
- `O_SUM`  out  OW  saturated total. Registered.
- `O_SAT`  out  1  total exceeded 2^OW-1. Registered, qualified by `O_VLD`.
- `O_VLD`  out  1  `O_SUM`/`O_SAT` are valid. Registered.
- `I_RDY`  in  1  downstream accepts the result.

## Operation

- Arithmetic is unsigned throughout.
- The state machine has two states, `S_ACC` and `S_OUT`.
- `S_ACC`:
  - `O_RDY` = 1.
  - A sample is accepted on an edge where `I_VLD` & `O_RDY`.
  - On acceptance: `acc <= (cnt==0) ? I_DATA : acc + I_DATA` and `cnt <= cnt+1`.
  - `I_VLD` = 0 is a bubble: `acc` and `cnt` are held.
  - On acceptance with `cnt==LEN-1`:
    - register `O_SUM <= (acc+I_DATA > 2^OW-1) ? 2^OW-1 : acc+I_DATA` (lower OW bits).
    - register `O_SAT` to match.
    - `O_VLD <= 1`, `O_RDY <= 0`, `cnt <= 0`, go to `S_OUT`.
  - With LEN=1, every accepted sample goes straight to `S_OUT`.
- `S_OUT`:
  - `O_RDY` = 0. `I_VLD` is ignored and no sample is consumed.
  - `O_SUM`, `O_SAT` and `O_VLD` hold stable until `I_RDY` = 1.
  - On an edge with `O_VLD` & `I_RDY`: `O_VLD <= 0`, `O_RDY <= 1`, go to `S_ACC`.
  - `O_SUM` and `O_SAT` keep their last value after the handshake but are don't-care while `O_VLD` = 0.
- Reset (`I_RST_N` = 0 at an edge):
  - state = `S_ACC`, `cnt` = 0, `acc` = 0.
  - `O_VLD` = 0, `O_RDY` = 0, `O_SUM` = 0, `O_SAT` = 0.
  - `O_RDY` becomes 1 at the first edge with `I_RST_N` = 1.
  - Reset mid-block discards the partial sum.
  - Reset while in `S_OUT` drops the pending result without a handshake.
- When `I_VLD` and reset are asserted together, reset wins and the sample is not accepted.
- Saturation is applied only at output. The internal `acc` never wraps.
- With the worst-case adder output 0x1FFFE and LEN samples, `acc` stays below 2^ACC_W.

## Timing

- Latency: `O_VLD` rises on the edge that accepts the LEN-th sample, so the result is visible in the following cycle.
- Throughput: at most one result per LEN+1 cycles. There is one dead cycle in `S_OUT`, even with `I_RDY` tied high.
- `S_OUT` never accepts a sample on the same edge as the output handshake. The first sample of the next block can be accepted at the earliest one cycle after `O_VLD` falls.
- Handshake rules:
  - Once `O_VLD` = 1, it stays 1 and `O_SUM`/`O_SAT` stay unchanged until `I_RDY` = 1 is sampled.
  - `O_RDY` does not depend combinationally on `I_VLD` or `I_RDY`.
- `I_DATA` is sampled only on accepting edges. Its value elsewhere has no effect.

## Test plan

All scenarios use W=16, LEN=4, OW=16.

1. Reset: hold `I_RST_N` = 0 for 5 cycles with `I_VLD` = 1 and `I_DATA` = 7.
   - Required: `O_VLD` = 0, `O_RDY` = 0, `O_SUM` = 0, `O_SAT` = 0 throughout.
   - Required: `O_RDY` = 1 in the first cycle after release, and no sample was counted.
2. Back-to-back: `I_DATA` = 1, 2, 3, 4 on consecutive cycles, `I_RDY` = 1.
   - Required: `O_VLD` = 1 for exactly one cycle, with `O_SUM` = 10 and `O_SAT` = 0.
   - Required: `O_RDY` = 0 during that cycle.
   - A following block of 5, 5, 5, 5 gives `O_SUM` = 20, which confirms there is no carry-over.
3. Saturation: four samples of 0x1FFFE.
   - Internal total is 0x7FFF8.
   - Required: `O_SUM` = 0xFFFF, `O_SAT` = 1.
   - A next block of 0x4000 ×4 gives 0xFFFF with `O_SAT` = 1, and a block of 0x3FFF ×4 gives 0xFFFC with `O_SAT` = 0.
4. Backpressure: after a result of 10, hold `I_RDY` = 0 for 10 cycles while driving `I_VLD` = 1 with `I_DATA` = 9.
   - Required: `O_VLD` = 1 and `O_SUM` = 10 stable, `O_RDY` = 0, and no sample consumed.
   - Raise `I_RDY`, then send 1, 1, 1, 1. Required: `O_SUM` = 4.
5. Bubbles: `I_VLD` pattern 1,0,1,0,0,1,0,1 with accepted data 5, 7, 9, 11.
   - Required: `O_SUM` = 32, with `O_VLD` rising the cycle after the 4th accept.
6. Mid-block reset: accept 100 and 200, pulse `I_RST_N` = 0 for one cycle, then send 1, 1, 1, 1.
   - Required: `O_SUM` = 4.
   - Reset asserted while `O_VLD` = 1 and `I_RDY` = 0 clears `O_VLD` on that edge.

Source files
------------

// File: rtl/adder_acc.sv
// adder_acc: reduces every LEN accepted (W+1)-bit sums into one total,
// presented saturated to OW bits with a saturation flag and a valid/ready
// handshake on both sides.
module adder_acc #(
  parameter int unsigned W   = 16,
  parameter int unsigned LEN = 4,
  parameter int unsigned OW  = 16
) (
  input  logic          I_CLK,
  input  logic          I_RST_N,
  input  logic [W:0]    I_DATA,
  input  logic          I_VLD,
  output logic          O_RDY,
  output logic [OW-1:0] O_SUM,
  output logic          O_SAT,
  output logic          O_VLD,
  input  logic          I_RDY
);

  // Accumulator is wide enough for LEN worst-case samples, so it never wraps.
  localparam int unsigned ACC_W = W + 1 + $clog2(LEN);
  localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  // Comparison width covers both the accumulator and the output range.
  localparam int unsigned CMP_W = (ACC_W > OW) ? ACC_W : OW;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
  localparam logic [CMP_W-1:0] MAX_OUT  = CMP_W'({OW{1'b1}});

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]      sum_q, sum_d;
  logic               sat_q, sat_d;
  logic               vld_q, vld_d;
  logic               rdy_q, rdy_d;

  logic               accept;
  logic [ACC_W-1:0]   acc_next;
  logic [CMP_W-1:0]   total;
  logic               over;

  // Datapath: running total including the sample offered this cycle.
  always_comb begin
    accept   = (state_q == S_ACC) && I_VLD && rdy_q;
    acc_next = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(I_DATA);
    total    = CMP_W'(acc_next);
    over     = (total > MAX_OUT);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    vld_d   = vld_q;
    rdy_d   = rdy_q;
    case (state_q)
      S_ACC: begin
        rdy_d = 1'b1;
        if (accept) begin
          acc_d = acc_next;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            sum_d   = over ? '1 : OW'(total);
            sat_d   = over;
            vld_d   = 1'b1;
            rdy_d   = 1'b0;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_OUT: begin
        rdy_d = 1'b0;
        if (vld_q && I_RDY) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_ACC;
        end
      end
      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  // State and output registers; reset drops any partial or pending result.
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign O_RDY = rdy_q;
  assign O_SUM = sum_q;
  assign O_SAT = sat_q;
  assign O_VLD = vld_q;

endmodule

// File: tb/tb_adder_acc.sv
// Directed bench for adder_acc (W=16, LEN=4, OW=16) with an expected-result
// queue filled when the LEN-th sample is accepted and drained on O_VLD.
module tb_adder_acc;

  logic        I_CLK;
  logic        I_RST_N;
  logic [16:0] I_DATA;
  logic        I_VLD;
  logic        O_RDY;
  logic [15:0] O_SUM;
  logic        O_SAT;
  logic        O_VLD;
  logic        I_RDY;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  int unsigned sb_acc = 0;
  int          sb_cnt = 0;

  adder_acc #(.W(16), .LEN(4), .OW(16)) dut (
    .I_CLK  (I_CLK),
    .I_RST_N(I_RST_N),
    .I_DATA (I_DATA),
    .I_VLD  (I_VLD),
    .O_RDY  (O_RDY),
    .O_SUM  (O_SUM),
    .O_SAT  (O_SAT),
    .O_VLD  (O_VLD),
    .I_RDY  (I_RDY)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  // Reference model: plain integer sum, saturated when a block completes.
  task automatic model_accept(input logic [16:0] d);
    logic sat;
    sb_acc += 32'(d);
    sb_cnt++;
    if (sb_cnt == 4) begin
      sat = (sb_acc > 32'd65535);
      exp_q.push_back({sat, sat ? 16'hFFFF : 16'(sb_acc)});
      sb_acc = 0;
      sb_cnt = 0;
    end
  endtask

  task automatic model_reset();
    sb_acc = 0;
    sb_cnt = 0;
  endtask

  task automatic send(input logic [16:0] d);
    int n = 0;
    I_VLD  = 1'b1;
    I_DATA = d;
    while (O_RDY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("send_rdy", 32'(O_RDY), 32'd1);
    tick();
    model_accept(d);
    I_VLD  = 1'b0;
    I_DATA = 17'h0;
  endtask

  // Wait for a result, compare against the queue head, then handshake.
  task automatic collect(input string tag);
    int n = 0;
    logic [16:0] e;
    while (O_VLD !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, 32'(O_VLD), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0;
    chk({tag, "_sum"}, 32'(O_SUM), 32'(e[15:0]));
    chk({tag, "_sat"}, 32'(O_SAT), 32'(e[16]));
    chk({tag, "_rdy_low"}, 32'(O_RDY), 32'd0);
    I_RDY = 1'b1;
    tick();
    chk({tag, "_vld_drop"}, 32'(O_VLD), 32'd0);
    chk({tag, "_rdy_back"}, 32'(O_RDY), 32'd1);
  endtask

  initial begin
    logic [16:0] discard;
    logic        bub_vld[8];
    logic [16:0] bub_dat[8];
    int          k;

    I_RST_N = 1'b0;
    I_VLD   = 1'b1;
    I_DATA  = 17'd7;
    I_RDY   = 1'b1;

    // 1. Reset held with a valid sample present.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_outs", 32'({O_VLD, O_RDY, O_SAT, O_SUM}), 32'd0);
    end
    I_RST_N = 1'b1;
    tick();
    chk("rst_release_rdy", 32'(O_RDY), 32'd1);
    chk("rst_release_vld", 32'(O_VLD), 32'd0);
    I_VLD  = 1'b0;
    I_DATA = 17'h0;

    // 2. Back-to-back blocks, no carry-over.
    send(17'd1); send(17'd2); send(17'd3); send(17'd4);
    collect("b2b_10");
    send(17'd5); send(17'd5); send(17'd5); send(17'd5);
    collect("b2b_20");

    // 3. Saturation boundaries.
    for (int i = 0; i < 4; i++) send(17'h1FFFE);
    collect("sat_max");
    for (int i = 0; i < 4; i++) send(17'h04000);
    collect("sat_exact");
    for (int i = 0; i < 4; i++) send(17'h03FFF);
    collect("sat_below");

    // 4. Backpressure: result held, offered samples ignored.
    I_RDY = 1'b0;
    send(17'd1); send(17'd2); send(17'd3); send(17'd4);
    I_VLD  = 1'b1;
    I_DATA = 17'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_vld", 32'(O_VLD), 32'd1);
      chk("bp_sum", 32'(O_SUM), 32'd10);
      chk("bp_rdy", 32'(O_RDY), 32'd0);
    end
    I_VLD  = 1'b0;
    I_DATA = 17'h0;
    collect("bp_10");
    send(17'd1); send(17'd1); send(17'd1); send(17'd1);
    collect("bp_after_4");

    // 5. Bubbles between accepted samples.
    bub_vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    k = 0;
    for (int i = 0; i < 8; i++) begin
      bub_dat[i] = 17'h1ABCD;
      if (bub_vld[i]) begin
        bub_dat[i] = 17'(5 + 2 * k);
        k++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      I_VLD  = bub_vld[i];
      I_DATA = bub_dat[i];
      chk("bub_rdy", 32'(O_RDY), 32'd1);
      tick();
      if (bub_vld[i]) model_accept(bub_dat[i]);
      if (i < 7) chk("bub_vld_early", 32'(O_VLD), 32'd0);
    end
    I_VLD  = 1'b0;
    I_DATA = 17'h0;
    chk("bub_latency", 32'(O_VLD), 32'd1);
    collect("bub_32");

    // 6. Reset mid-block discards the partial sum.
    send(17'd100); send(17'd200);
    I_RST_N = 1'b0;
    tick();
    model_reset();
    I_RST_N = 1'b1;
    tick();
    chk("mid_rst_rdy", 32'(O_RDY), 32'd1);
    send(17'd1); send(17'd1); send(17'd1); send(17'd1);
    collect("mid_rst_4");

    // Reset while a result is pending drops it without a handshake.
    I_RDY = 1'b0;
    send(17'd3); send(17'd3); send(17'd3); send(17'd3);
    chk("out_rst_pending", 32'(O_VLD), 32'd1);
    discard = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0;
    I_RST_N = 1'b0;
    tick();
    chk("out_rst_vld", 32'(O_VLD), 32'd0);
    chk("out_rst_rdy", 32'(O_RDY), 32'd0);
    model_reset();
    I_RST_N = 1'b1;
    tick();
    send(17'd2); send(17'd2); send(17'd2); send(17'd2);
    collect("out_rst_8");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
